cfg_reg_arbiter: RTL and testbench

CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

---
 rtl/cfg_reg_arbiter_if.sv | 34 +++
 rtl/cfg_reg_arbiter.sv | 134 +++++++++++++
 tb/tb_cfg_reg_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_reg_arbiter_if
//  Brief    : Write-request bundle shared by the two config-register
//             requesters (SPI decoder on port 0, sequencer on port 1) and
//             the arbiter that completes their writes.
//  Revision : 1.0  initial release
// ============================================================================
interface cfg_reg_arbiter_if;
    logic       p0_valid;
    logic [6:0] p0_addr;
    logic [7:0] p0_data;
    logic       p0_ack;
    logic       p1_valid;
    logic [6:0] p1_addr;
    logic [7:0] p1_data;
    logic       p1_ack;
    logic       err;

    // Requester side: drives requests, observes completion.
    modport master (
        output p0_valid, p0_addr, p0_data,
        output p1_valid, p1_addr, p1_data,
        input  p0_ack, p1_ack, err
    );

    // Arbiter side: observes requests, drives completion.
    modport slave (
        input  p0_valid, p0_addr, p0_data,
        input  p1_valid, p1_addr, p1_data,
        output p0_ack, p1_ack, err
    );
endinterface
`default_nettype wire

// File: rtl/cfg_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_reg_arbiter
//  Brief    : Two-port config-register write arbiter. A request is captured
//             in IDLE, committed in WRITE and acknowledged for one cycle in
//             ACK. Round-robin or fixed-priority arbitration between ports.
//  Revision : 1.0  initial release
// ============================================================================
module cfg_reg_arbiter #(
    parameter int RR_EN    = 1,
    parameter int NUM_REGS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    cfg_reg_arbiter_if.slave bus,
    output logic [7:0]       en_reg_out_7_0,
    output logic [7:0]       en_reg_out_15_8,
    output logic [7:0]       en_reg_pwm_7_0,
    output logic [7:0]       en_reg_pwm_15_8,
    output logic [7:0]       pwm_duty_cycle,
    output logic             wr_strobe,
    output logic [6:0]       wr_addr
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_ack   = 2'd2;

    // One extra bit so that NUM_REGS = 128 still compares correctly.
    localparam logic [7:0] c_num_regs = 8'(NUM_REGS);
    localparam logic       c_rr_en    = (RR_EN != 0);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last_p1;   // 1 = port 1 was granted most recently
    logic       r_gnt_p1;    // grant owner of the transaction in flight
    logic [6:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_regs [NUM_REGS];
    logic [7:0] w_reg_view [5];

    logic w_any_valid;
    logic w_pick_p1;
    logic w_addr_ok;

    assign w_any_valid = bus.p0_valid | bus.p1_valid;
    // Port 1 wins when alone, or on a tie when round-robin says port 0 had the last turn.
    assign w_pick_p1   = bus.p1_valid & (~bus.p0_valid | (c_rr_en & ~r_last_p1));
    // Full 7-bit compare: high address bits never alias onto a real register.
    assign w_addr_ok   = ({1'b0, r_addr} < c_num_regs);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: capture, commit, one ack cycle in which requests are ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_any_valid) w_state_nxt = c_st_write;
            c_st_write: w_state_nxt = c_st_ack;
            c_st_ack:   w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Request capture, register commit and registered completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_p1  <= 1'b1;
            r_gnt_p1   <= 1'b0;
            r_addr     <= 7'd0;
            r_data     <= 8'd0;
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            bus.err    <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 7'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            bus.err    <= 1'b0;
            wr_strobe  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any_valid) begin
                        r_gnt_p1  <= w_pick_p1;
                        r_last_p1 <= w_pick_p1;
                        r_addr    <= w_pick_p1 ? bus.p1_addr : bus.p0_addr;
                        r_data    <= w_pick_p1 ? bus.p1_data : bus.p0_data;
                    end
                end
                c_st_write: begin
                    bus.p0_ack <= ~r_gnt_p1;
                    bus.p1_ack <= r_gnt_p1;
                    bus.err    <= ~w_addr_ok;
                    wr_strobe  <= w_addr_ok;
                    wr_addr    <= r_addr;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_addr_ok && (r_addr == 7'(i))) begin
                            r_regs[i] <= r_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Map the first five register slots onto the named outputs; absent slots read zero.
    for (genvar gi = 0; gi < 5; gi++) begin : g_view
        if (gi < NUM_REGS) begin : g_impl
            assign w_reg_view[gi] = r_regs[gi];
        end else begin : g_none
            assign w_reg_view[gi] = 8'h00;
        end
    end

    assign en_reg_out_7_0  = w_reg_view[0];
    assign en_reg_out_15_8 = w_reg_view[1];
    assign en_reg_pwm_7_0  = w_reg_view[2];
    assign en_reg_pwm_15_8 = w_reg_view[3];
    assign pwm_duty_cycle  = w_reg_view[4];

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_reg_arbiter
//  Brief    : Directed bench for cfg_reg_arbiter. One instance runs
//             round-robin, a second runs fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cfg_reg_arbiter;

    logic clk;
    logic rst_n;

    cfg_reg_arbiter_if bus_rr ();
    cfg_reg_arbiter_if bus_fp ();

    logic [7:0] rr_out_lo, rr_out_hi, rr_pwm_lo, rr_pwm_hi, rr_duty;
    logic       rr_strobe;
    logic [6:0] rr_waddr;
    logic [7:0] fp_out_lo, fp_out_hi, fp_pwm_lo, fp_pwm_hi, fp_duty;
    logic       fp_strobe;
    logic [6:0] fp_waddr;

    int checks = 0;
    int errors = 0;

    cfg_reg_arbiter #(.RR_EN(1), .NUM_REGS(5)) u_dut_rr (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_rr),
        .en_reg_out_7_0  (rr_out_lo),
        .en_reg_out_15_8 (rr_out_hi),
        .en_reg_pwm_7_0  (rr_pwm_lo),
        .en_reg_pwm_15_8 (rr_pwm_hi),
        .pwm_duty_cycle  (rr_duty),
        .wr_strobe       (rr_strobe),
        .wr_addr         (rr_waddr)
    );

    cfg_reg_arbiter #(.RR_EN(0), .NUM_REGS(5)) u_dut_fp (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_fp),
        .en_reg_out_7_0  (fp_out_lo),
        .en_reg_out_15_8 (fp_out_hi),
        .en_reg_pwm_7_0  (fp_pwm_lo),
        .en_reg_pwm_15_8 (fp_pwm_hi),
        .pwm_duty_cycle  (fp_duty),
        .wr_strobe       (fp_strobe),
        .wr_addr         (fp_waddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rr_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        chk({tag, "_reg0"}, 32'(rr_out_lo), 32'(e0));
        chk({tag, "_reg1"}, 32'(rr_out_hi), 32'(e1));
        chk({tag, "_reg2"}, 32'(rr_pwm_lo), 32'(e2));
        chk({tag, "_reg3"}, 32'(rr_pwm_hi), 32'(e3));
        chk({tag, "_reg4"}, 32'(rr_duty),   32'(e4));
    endtask

    initial begin
        rst_n = 1'b0;
        bus_rr.p0_valid = 1'b0; bus_rr.p0_addr = 7'd0; bus_rr.p0_data = 8'd0;
        bus_rr.p1_valid = 1'b0; bus_rr.p1_addr = 7'd0; bus_rr.p1_data = 8'd0;
        bus_fp.p0_valid = 1'b0; bus_fp.p0_addr = 7'd0; bus_fp.p0_data = 8'd0;
        bus_fp.p1_valid = 1'b0; bus_fp.p1_addr = 7'd0; bus_fp.p1_data = 8'd0;

        // ---- reset state ----
        tick(); tick();
        chk_rr_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rst_p0_ack", 32'(bus_rr.p0_ack), 32'd0);
        chk("rst_p1_ack", 32'(bus_rr.p1_ack), 32'd0);
        chk("rst_err",    32'(bus_rr.err),    32'd0);
        chk("rst_strobe", 32'(rr_strobe),     32'd0);
        chk("rst_waddr",  32'(rr_waddr),      32'd0);
        rst_n = 1'b1;
        tick();

        // ---- p0 writes 0x80 to addr 4 ----
        bus_rr.p0_valid = 1'b1; bus_rr.p0_addr = 7'd4; bus_rr.p0_data = 8'h80;
        tick();
        chk("a_grant_no_ack", 32'(bus_rr.p0_ack), 32'd0);
        chk("a_grant_duty",   32'(rr_duty),       32'h00);
        tick();
        chk("a_duty",   32'(rr_duty),       32'h80);
        chk("a_p0_ack", 32'(bus_rr.p0_ack), 32'd1);
        chk("a_p1_ack", 32'(bus_rr.p1_ack), 32'd0);
        chk("a_strobe", 32'(rr_strobe),     32'd1);
        chk("a_waddr",  32'(rr_waddr),      32'd4);
        chk("a_err",    32'(bus_rr.err),    32'd0);
        bus_rr.p0_valid = 1'b0;
        tick();
        chk("a_ack_done",    32'(bus_rr.p0_ack), 32'd0);
        chk("a_strobe_done", 32'(rr_strobe),     32'd0);

        // ---- p0 to address 0x45 (upper bits set, no aliasing) ----
        bus_rr.p0_valid = 1'b1; bus_rr.p0_addr = 7'h45; bus_rr.p0_data = 8'h77;
        tick(); tick();
        chk("alias_p0_ack", 32'(bus_rr.p0_ack), 32'd1);
        chk("alias_err",    32'(bus_rr.err),    32'd1);
        chk("alias_strobe", 32'(rr_strobe),     32'd0);
        chk_rr_regs("alias", 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
        bus_rr.p0_valid = 1'b0;
        tick();

        // ---- p1 writes 0xFF to invalid addr 7 ----
        bus_rr.p1_valid = 1'b1; bus_rr.p1_addr = 7'd7; bus_rr.p1_data = 8'hFF;
        tick(); tick();
        chk("b_p1_ack", 32'(bus_rr.p1_ack), 32'd1);
        chk("b_p0_ack", 32'(bus_rr.p0_ack), 32'd0);
        chk("b_err",    32'(bus_rr.err),    32'd1);
        chk("b_strobe", 32'(rr_strobe),     32'd0);
        chk_rr_regs("b", 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
        bus_rr.p1_valid = 1'b0;
        tick();
        chk("b_err_done", 32'(bus_rr.err), 32'd0);

        // ---- both ports continuously, round-robin: p0, p1, p0 ----
        bus_rr.p0_valid = 1'b1; bus_rr.p0_addr = 7'd0; bus_rr.p0_data = 8'hAA;
        bus_rr.p1_valid = 1'b1; bus_rr.p1_addr = 7'd0; bus_rr.p1_data = 8'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr_wait_p0", 32'(bus_rr.p0_ack), 32'd0);
            chk("rr_wait_p1", 32'(bus_rr.p1_ack), 32'd0);
            tick();
            chk("rr_p0_ack", 32'(bus_rr.p0_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_p1_ack", 32'(bus_rr.p1_ack), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_reg0",   32'(rr_out_lo),     (k % 2 == 0) ? 32'hAA : 32'h55);
            tick();
        end
        bus_rr.p0_valid = 1'b0;
        bus_rr.p1_valid = 1'b0;

        // ---- same stimulus, fixed priority: p1 waits until p0 drops ----
        bus_fp.p0_valid = 1'b1; bus_fp.p0_addr = 7'd0; bus_fp.p0_data = 8'hAA;
        bus_fp.p1_valid = 1'b1; bus_fp.p1_addr = 7'd0; bus_fp.p1_data = 8'h55;
        for (int k = 0; k < 3; k++) begin
            tick(); tick();
            chk("fp_p0_ack", 32'(bus_fp.p0_ack), 32'd1);
            chk("fp_p1_ack", 32'(bus_fp.p1_ack), 32'd0);
            chk("fp_reg0",   32'(fp_out_lo),     32'hAA);
            if (k == 2) bus_fp.p0_valid = 1'b0;
            tick();
        end
        tick();
        chk("fp_p1_wait", 32'(bus_fp.p1_ack), 32'd0);
        tick();
        chk("fp_p1_ack",  32'(bus_fp.p1_ack), 32'd1);
        chk("fp_p0_idle", 32'(bus_fp.p0_ack), 32'd0);
        chk("fp_reg0_p1", 32'(fp_out_lo),     32'h55);
        bus_fp.p1_valid = 1'b0;
        tick();

        // ---- reset asserted while in WRITE aborts the transaction ----
        bus_rr.p0_valid = 1'b1; bus_rr.p0_addr = 7'd2; bus_rr.p0_data = 8'h3C;
        tick();
        rst_n = 1'b0;
        bus_rr.p0_valid = 1'b0;
        #2;
        chk("d_async_reg0", 32'(rr_out_lo),     32'h00);
        chk("d_async_duty", 32'(rr_duty),       32'h00);
        chk("d_async_ack",  32'(bus_rr.p0_ack), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("d_no_ack_1", 32'(bus_rr.p0_ack), 32'd0);
        tick();
        chk("d_no_ack_2", 32'(bus_rr.p0_ack), 32'd0);
        chk("d_pwm_lo",   32'(rr_pwm_lo),     32'h00);
        bus_rr.p0_valid = 1'b1;
        tick(); tick();
        chk("d_retry_ack", 32'(bus_rr.p0_ack), 32'd1);
        chk("d_retry_pwm", 32'(rr_pwm_lo),     32'h3C);
        bus_rr.p0_valid = 1'b0;
        tick();

        // ---- back-to-back from p0: ACK cycle ignores the held request ----
        bus_rr.p0_valid = 1'b1; bus_rr.p0_addr = 7'd0; bus_rr.p0_data = 8'h22;
        tick(); tick();
        chk("e_first_ack",  32'(bus_rr.p0_ack), 32'd1);
        chk("e_first_reg0", 32'(rr_out_lo),     32'h22);
        bus_rr.p0_addr = 7'd1; bus_rr.p0_data = 8'h11;
        tick();
        chk("e_ackcyc_ack",  32'(bus_rr.p0_ack), 32'd0);
        chk("e_ackcyc_reg1", 32'(rr_out_hi),     32'h00);
        tick();
        chk("e_grant_ack",  32'(bus_rr.p0_ack), 32'd0);
        chk("e_grant_reg1", 32'(rr_out_hi),     32'h00);
        tick();
        chk("e_second_ack",   32'(bus_rr.p0_ack), 32'd1);
        chk("e_second_reg1",  32'(rr_out_hi),     32'h11);
        chk("e_second_waddr", 32'(rr_waddr),      32'd1);
        bus_rr.p0_valid = 1'b0;
        tick();
        chk_rr_regs("final", 8'h22, 8'h11, 8'h3C, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
